serial_parity_frame_rx: RTL and testbench
=========================================

Name: serial_parity_frame_rx

Overview:
- Serial front-end directly upstream of even_parity_checker.
- Deserialises one asynchronous-style frame: start bit, DATA_W data bits LSB-first, one parity bit, one stop bit.
- Presents data1 and parity_bit as registered parallel outputs that connect straight into the checker.
- Does not check parity; that belongs to the downstream checker. It only reports framing (stop-bit) errors.

Parameters:
- DATA_W, 8: data bits per frame. The checker's data1 port is fixed at 8 bits.
- CLKS_PER_BIT, 4: clk cycles per serial bit. Must be ≥2. Mid-bit offset HALF = CLKS_PER_BIT/2 (integer).

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- rx_in, input, 1: serial line. Idle level is 1. Synchronous to clk; no internal synchroniser.
- data1, output, DATA_W: last good frame's data, MSB = last data bit received.
- parity_bit, output, 1: last good frame's received parity bit.
- frame_valid, output, 1: one-cycle pulse; data1/parity_bit updated in the same cycle.
- framing_error, output, 1: one-cycle pulse when the stop bit samples 0.
- busy, output, 1: high whenever state ≠ IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - State → IDLE; counters → 0.
  - data1, parity_bit, frame_valid, framing_error, busy all → 0.
  - Reset overrides everything, including mid-frame; a partial frame is discarded silently.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: rx_in sampled 0 at edge E → START, bit counter cleared.
- START: at edge E+HALF, re-sample rx_in.
  - 0 → DATA.
  - 1 → IDLE (glitch rejected; no pulse).
- DATA: data bit i (i = 0..DATA_W-1) sampled at E+HALF+(i+1)*CLKS_PER_BIT into shift register bit i. After bit DATA_W-1 → PARITY.
- PARITY: sampled at E+HALF+(DATA_W+1)*CLKS_PER_BIT → STOP.
- STOP: sampled at E+HALF+(DATA_W+2)*CLKS_PER_BIT.
  - 1: on that edge, load data1 and parity_bit from the shift/parity registers and set frame_valid=1 for exactly one cycle → IDLE.
  - 0: framing_error=1 for one cycle; data1 and parity_bit hold old values; no frame_valid → WAIT_IDLE.
- WAIT_IDLE: stay until rx_in sampled 1, then → IDLE. A 0 seen here is never treated as a start.
- Latency: with defaults, the frame_valid cycle follows edge E+42.
- Back-to-back frames: a start bit beginning immediately after the stop-bit period is detected. IDLE is re-entered right after the stop sample, HALF cycles before the stop period ends.
- Pulses are never asserted in the same cycle as each other.
- Outputs are all registered; no combinational path from rx_in to any output.
- Bit counter width: clog2(DATA_W+1). Cycle counter width: clog2(CLKS_PER_BIT). Cycle counter wraps to 0 on each sample.

Decomposition:
- Shared package serial_rx_pkg:
  - state enum (6 states, 3-bit encoding);
  - LINE_IDLE = 1'b1;
  - START_LEVEL = 1'b0.
- Sub-module bit_period_counter:
  - parameterised by CLKS_PER_BIT;
  - inputs: clk, rst, clear, first_half;
  - output: sample_tick, which pulses after HALF cycles when first_half=1, otherwise after CLKS_PER_BIT cycles.
- The top FSM owns the shift register, bit counter, and output registers.

Test Plan:
- Reset with rx_in=1 for 20 cycles → data1=0, parity_bit=0, busy=0, no pulses.
- Frame 0x3C (00111100), parity 0, stop 1 → frame_valid single pulse in the cycle after edge E+42; data1=8'b00111100, parity_bit=0. The downstream checker error is 0.
- Frame 0x1C, parity 0, stop 1 → data1=8'b00011100, parity_bit=0 passed through unchanged. The checker flags error=1.
- Frame 0x3D, parity 1, stop 0 → framing_error pulse, no frame_valid, data1 stays 0x1C. busy stays high until rx_in returns to 1.
- Glitch on rx_in: low for 1 cycle only → busy high for HALF cycles, then IDLE; no pulse, outputs unchanged.
- rst asserted at the 4th data bit of a frame → next cycle busy=0 and all outputs 0. A following clean frame 0x3C/parity 0 is received correctly.
- Two frames back-to-back (0x3C then 0x1C with parity 1) → two frame_valid pulses 44 cycles apart with the correct data each.

Source files
------------

// File: rtl/serial_parity_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_rx_pkg
// Description : Shared state encoding and line-level constants for the
//               serial parity frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_rx_pkg;

  // Receiver FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Level of the serial line when nothing is being sent
  localparam logic LINE_IDLE   = 1'b1;
  // Level that marks a start bit
  localparam logic START_LEVEL = 1'b0;

endpackage : serial_rx_pkg
`default_nettype wire

// File: rtl/serial_parity_frame_rx_bit_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : bit_period_counter
// Description : Bit-period timer. Produces sample_tick HALF cycles after
//               clear drops when first_half is set, otherwise every
//               CLKS_PER_BIT cycles. Wraps to zero on every tick.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic first_half,
  output logic sample_tick
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_target;

  assign w_target    = first_half ? HALF_M1 : FULL_M1;
  assign sample_tick = (r_cnt == w_target) && !clear;

  // Cycle counter: held at zero while cleared, wraps on each sample point
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (sample_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule : bit_period_counter
`default_nettype wire

// File: rtl/serial_parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_frame_rx
// Description : Deserialises start / DATA_W data (LSB first) / parity / stop
//               frames and presents data + received parity bit as registered
//               outputs. Reports stop-bit framing errors; parity is left to
//               the downstream checker.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data1,
  output logic              parity_bit,
  output logic              frame_valid,
  output logic              framing_error,
  output logic              busy
);

  localparam int            BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  rx_state_t         r_state;
  logic [BW-1:0]     r_bitcnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [DATA_W-1:0] r_data;
  logic              r_parity_out;
  logic              r_fv;
  logic              r_fe;
  logic              r_busy;

  logic w_clear;
  logic w_first_half;
  logic w_tick;

  // Timer is parked at zero while waiting for the line, so the first count
  // after the start edge lines up with the mid-bit sample point.
  assign w_clear      = (r_state == ST_IDLE) || (r_state == ST_WAIT_IDLE);
  assign w_first_half = (r_state == ST_START);

  bit_period_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_period_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (w_clear),
    .first_half  (w_first_half),
    .sample_tick (w_tick)
  );

  // Frame FSM: owns shift register, bit counter and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_data       <= '0;
      r_parity_out <= 1'b0;
      r_fv         <= 1'b0;
      r_fe         <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      r_fe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_in == START_LEVEL) begin
            r_state  <= ST_START;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (rx_in == START_LEVEL) begin
              r_state <= ST_DATA;
            end else begin
              // Start bit did not persist to mid-bit: treat as a glitch
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            // LSB arrives first, so shifting right leaves bit i in slot i
            r_shift <= {rx_in, r_shift[DATA_W-1:1]};
            if (r_bitcnt == LAST_BIT) begin
              r_state <= ST_PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_par   <= rx_in;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (rx_in == LINE_IDLE) begin
              r_data       <= r_shift;
              r_parity_out <= r_par;
              r_fv         <= 1'b1;
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
            end else begin
              // Bad stop bit: keep previous good data, wait for line release
              r_fe    <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_in == LINE_IDLE) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data1         = r_data;
  assign parity_bit    = r_parity_out;
  assign frame_valid   = r_fv;
  assign framing_error = r_fe;
  assign busy          = r_busy;

endmodule : serial_parity_frame_rx
`default_nettype wire

// File: tb/tb_serial_parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_frame_rx
// Description : Self-checking bench for serial_parity_frame_rx. Directed
//               frames are driven on rx_in; expected pulses are queued and
//               matched against DUT output pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parity_frame_rx;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;

  logic          clk;
  logic          rst;
  logic          rx_in;
  logic [DW-1:0] data1;
  logic          parity_bit;
  logic          frame_valid;
  logic          framing_error;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit            fe;
    logic [DW-1:0] data;
    logic          par;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] last_d = '0;
  logic          last_p = 1'b0;

  serial_parity_frame_rx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .data1         (data1),
    .parity_bit    (parity_bit),
    .frame_valid   (frame_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call just after a posedge (+1). Queues the expected pulse, then drives
  // start, data LSB first, parity and stop, each for CPB cycles.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    exp_t        e;
    logic [10:0] bits;
    bits  = {s, p, d, 1'b0};
    e.fe  = !s;
    e.data = s ? d : last_d;
    e.par  = s ? p : last_p;
    e.cyc  = cyc + 1 + HALF + (DW + 2) * CPB;
    sb.push_back(e);
    if (s) begin
      last_d = d;
      last_p = p;
    end
    for (int j = 0; j < 11; j++) begin
      rx_in = bits[j];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (frame_valid === 1'b1 || framing_error === 1'b1) begin
      check("pulse_exclusive", {31'd0, (frame_valid & framing_error)}, 32'd0);
      check("pulse_expected", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("pulse_kind_fe", {31'd0, framing_error}, {31'd0, mon_e.fe});
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_data1", {24'd0, data1}, {24'd0, mon_e.data});
        check("pulse_parity", {31'd0, parity_bit}, {31'd0, mon_e.par});
        check("checker_err", {31'd0, ^{data1, parity_bit}},
              {31'd0, ^{mon_e.data, mon_e.par}});
      end
    end
  end

  // Runaway guard
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with idle line
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_data1", {24'd0, data1}, 32'h0);
    check("rst_parity", {31'd0, parity_bit}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_fv", {31'd0, frame_valid}, 32'h0);
    check("rst_fe", {31'd0, framing_error}, 32'h0);
    rst = 1'b0;
    idle_cycles(5);

    // Good frame, even parity satisfied
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_cycles(4);
    check("f1_drain", sb.size(), 32'd0);
    check("f1_busy", {31'd0, busy}, 32'h0);

    // Good frame, parity wrong: passed through unchanged
    send_frame(8'h1C, 1'b0, 1'b1);
    idle_cycles(4);
    check("f2_drain", sb.size(), 32'd0);

    // Bad stop bit: line held low afterwards, 0s must not restart a frame
    send_frame(8'h3D, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("fe_drain", sb.size(), 32'd0);
    check("fe_busy_hold", {31'd0, busy}, 32'h1);
    check("fe_data_hold", {24'd0, data1}, 32'h1C);
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    check("fe_busy_release", {31'd0, busy}, 32'h0);
    idle_cycles(4);

    // One-cycle glitch: busy for HALF cycles, then back to idle
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    rx_in = 1'b1;
    check("glitch_busy_a", {31'd0, busy}, 32'h1);
    @(posedge clk);
    #1;
    check("glitch_busy_b", {31'd0, busy}, 32'h1);
    @(posedge clk);
    #1;
    check("glitch_busy_end", {31'd0, busy}, 32'h0);
    idle_cycles(10);
    check("glitch_data_hold", {24'd0, data1}, 32'h1C);

    // Reset in the middle of data bit 3 of a 0x3C frame
    rx_in = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx_in = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (CPB + 2) @(posedge clk);
    #1;
    check("mid_busy_pre", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'h0);
    check("mid_rst_data1", {24'd0, data1}, 32'h0);
    check("mid_rst_parity", {31'd0, parity_bit}, 32'h0);
    last_d = '0;
    last_p = 1'b0;
    idle_cycles(10);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_cycles(4);
    check("post_rst_drain", sb.size(), 32'd0);

    // Back-to-back frames, 44 cycles apart
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    idle_cycles(10);
    check("b2b_drain", sb.size(), 32'd0);
    check("b2b_final_data", {24'd0, data1}, 32'h1C);
    check("b2b_final_par", {31'd0, parity_bit}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_parity_frame_rx
`default_nettype wire
